// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multicycle MIPS control FSM with memory wait timeout
module mips_multicycle_control #(
   parameter int MAX_WAIT        = 15,
   parameter bit TRAP_ON_ILLEGAL = 1'b1,
   parameter bit ENABLE_BNE      = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       pcen,
   output logic       regwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alu_control,
   output logic [3:0] state_out,
   output logic       illegal,
   output logic       timeout
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BRANCH  = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11,
      ERR     = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // Counter wide enough to hold MAX_WAIT; saturates at all-ones.
   localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [WW-1:0] WAIT_SAT  = '1;
   localparam logic [WW-1:0] WAIT_LAST = (MAX_WAIT > 0) ? WW'(MAX_WAIT - 1) : '0;

   typedef struct packed {
      logic       mem_req;
      logic       iord;
      logic       memwrite;
      logic       regwrite;
      logic       regdst;
      logic       memtoreg;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [2:0] alu_control;
   } ctrl_t;

   state_t        state;
   state_t        state_next;
   ctrl_t         ctrl;
   logic [WW-1:0] wait_cnt;
   logic          wait_hit;
   logic          set_illegal;
   logic          set_timeout;
   logic          wait_clear;

   // Moore control word for a given state; funct only matters in RTYPEEX.
   function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] f);
      ctrl_t c;
      c = '0;
      c.alu_control = ALU_ADD;
      case (s)
         FETCH: begin
            c.mem_req = 1'b1;
            c.alusrcb = 2'b01;
         end
         DECODE:  c.alusrcb = 2'b11;
         MEMADR: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
         end
         MEMRD: begin
            c.mem_req = 1'b1;
            c.iord    = 1'b1;
         end
         MEMWB: begin
            c.regwrite = 1'b1;
            c.memtoreg = 1'b1;
         end
         MEMWR: begin
            c.mem_req  = 1'b1;
            c.iord     = 1'b1;
            c.memwrite = 1'b1;
         end
         RTYPEEX: begin
            c.alusrca = 1'b1;
            case (f)
               6'b100010: c.alu_control = ALU_SUB;
               6'b100100: c.alu_control = ALU_AND;
               6'b100101: c.alu_control = ALU_OR;
               6'b101010: c.alu_control = ALU_SLT;
               default:   c.alu_control = ALU_ADD;
            endcase
         end
         RTYPEWB: begin
            c.regwrite = 1'b1;
            c.regdst   = 1'b1;
         end
         BRANCH: begin
            c.alusrca     = 1'b1;
            c.alu_control = ALU_SUB;
            c.pcsrc       = 2'b01;
         end
         ADDIEX: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
         end
         ADDIWB:  c.regwrite = 1'b1;
         JUMP:    c.pcsrc = 2'b10;
         default: c = c;
      endcase
      return c;
   endfunction

   // Timeout fires on the last permitted wait cycle of a still-unanswered request.
   assign wait_hit = (MAX_WAIT > 0) && mem_req && !mem_ready && (wait_cnt == WAIT_LAST);

   // Next-state selection and sticky-flag set conditions.
   always_comb begin
      state_next  = state;
      set_illegal = 1'b0;
      set_timeout = 1'b0;
      case (state)
         FETCH: begin
            if (wait_hit) begin
               state_next  = ERR;
               set_timeout = 1'b1;
            end else if (mem_ready) begin
               state_next = DECODE;
            end
         end
         DECODE: begin
            if (op == OP_LW || op == OP_SW)          state_next = MEMADR;
            else if (op == OP_RTYPE)                 state_next = RTYPEEX;
            else if (op == OP_BEQ)                   state_next = BRANCH;
            else if (op == OP_BNE && ENABLE_BNE)     state_next = BRANCH;
            else if (op == OP_ADDI)                  state_next = ADDIEX;
            else if (op == OP_J)                     state_next = JUMP;
            else if (TRAP_ON_ILLEGAL) begin
               state_next  = ERR;
               set_illegal = 1'b1;
            end else begin
               state_next = FETCH;
            end
         end
         MEMADR:  state_next = (op == OP_SW) ? MEMWR : MEMRD;
         MEMRD: begin
            if (wait_hit) begin
               state_next  = ERR;
               set_timeout = 1'b1;
            end else if (mem_ready) begin
               state_next = MEMWB;
            end
         end
         MEMWR: begin
            if (wait_hit) begin
               state_next  = ERR;
               set_timeout = 1'b1;
            end else if (mem_ready) begin
               state_next = FETCH;
            end
         end
         MEMWB, RTYPEWB, BRANCH, ADDIWB, JUMP: state_next = FETCH;
         RTYPEEX: state_next = RTYPEWB;
         ADDIEX:  state_next = ADDIWB;
         ERR:     state_next = ERR;
         default: state_next = ERR;
      endcase
   end

   // Counter restarts whenever a memory-access state is freshly entered.
   assign wait_clear = (state_next != state) &&
                       (state_next == FETCH || state_next == MEMRD || state_next == MEMWR);

   // State, registered Moore outputs, wait counter and sticky flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= FETCH;
         ctrl     <= decode_ctrl(FETCH, funct);
         wait_cnt <= '0;
         illegal  <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         state <= state_next;
         ctrl  <= decode_ctrl(state_next, funct);
         if (wait_clear)
            wait_cnt <= '0;
         else if (mem_req && !mem_ready && wait_cnt != WAIT_SAT)
            wait_cnt <= wait_cnt + 1'b1;
         if (set_illegal) illegal <= 1'b1;
         if (set_timeout) timeout <= 1'b1;
      end
   end

   assign mem_req     = ctrl.mem_req;
   assign iord        = ctrl.iord;
   assign memwrite    = ctrl.memwrite;
   assign regwrite    = ctrl.regwrite;
   assign regdst      = ctrl.regdst;
   assign memtoreg    = ctrl.memtoreg;
   assign alusrca     = ctrl.alusrca;
   assign alusrcb     = ctrl.alusrcb;
   assign pcsrc       = ctrl.pcsrc;
   assign alu_control = ctrl.alu_control;
   assign state_out   = state;

   assign irwrite = (state == FETCH) && mem_ready;
   assign pcen    = irwrite ||
                    (state == JUMP) ||
                    ((state == BRANCH) && ((op == OP_BNE) ? !zero : zero));

endmodule
